// File: rtl/aes_pkg.sv
// Shared AES definitions: round count, rcon table, key-schedule FSM state
// type, and helpers that convert between 128-bit keys and 32-bit words.
// Key byte k sits at bits [8k+7:8k]. Word j holds bytes 4j..4j+3, with
// byte 4j in bits [31:24].
package aes_pkg;

  localparam int AES_NR = 10;

  typedef logic [1:0] key_state_t;
  localparam key_state_t ST_IDLE = 2'd0;
  localparam key_state_t ST_RUN  = 2'd1;
  localparam key_state_t ST_DONE = 2'd2;

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  endfunction

  function automatic logic [31:0] key_word(input logic [127:0] key, input int j);
    logic [31:0] w;
    w = '0;
    for (int b = 0; b < 4; b++) w[31-8*b -: 8] = key[8*(4*j+b) +: 8];
    return w;
  endfunction

  function automatic logic [127:0] words_to_key(input logic [31:0] w0, input logic [31:0] w1,
                                                input logic [31:0] w2, input logic [31:0] w3);
    logic [3:0][31:0] ws;
    logic [127:0]     k;
    ws = {w3, w2, w1, w0};
    k  = '0;
    for (int j = 0; j < 4; j++)
      for (int b = 0; b < 4; b++) k[8*(4*j+b) +: 8] = ws[j][31-8*b -: 8];
    return k;
  endfunction

endpackage

// File: rtl/aes_key_reverse_if.sv
// Handshake and key bus between the reverse key schedule (slave) and the
// loader / inverse-cipher consumer (master).
interface aes_key_reverse_if;
  logic         key_in_valid;
  logic         key_in_ready;
  logic [127:0] key_in;
  logic         key_next;
  logic [127:0] key_out;
  logic [3:0]   key_addr;
  logic         key_loaded;

  modport master (
    output key_in_valid, key_in, key_next,
    input  key_in_ready, key_out, key_addr, key_loaded
  );

  modport slave (
    input  key_in_valid, key_in, key_next,
    output key_in_ready, key_out, key_addr, key_loaded
  );
endinterface

// File: rtl/aes_sbox.sv
// Forward AES S-box, the same table used by the cipher datapath.
module aes_sbox (
  input  logic [7:0] plain,
  output logic [7:0] subst
);
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry x starts at bit 2047-8x, which is {~x, 3'b111}.
  assign subst = SBOX[{~plain, 3'b111} -: 8];
endmodule

// File: rtl/aes_key_reverse.sv
// AES-128 reverse key schedule: takes the round-10 key and walks the round
// keys back from address 11 to 1, one per consumer request.
// Build option: AES_KEY_ZEROIZE_EN clears the key register on entry to DONE.
module aes_key_reverse
  import aes_pkg::*;
(
  input logic              clk,
  input logic              rst_n,
  aes_key_reverse_if.slave bus
);

  key_state_t   state;
  logic [127:0] key_p0;
  logic [3:0]   addr_p0;
  logic [3:0]   rnd_p0;
  logic         loaded_p0;

  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  w0n, w1n, w2n, w3n;
  logic [31:0]  rot, sub;
  logic [127:0] key_prev;

  // Reverse step: recover the previous round key from the current one.
  assign w0  = key_word(key_p0, 0);
  assign w1  = key_word(key_p0, 1);
  assign w2  = key_word(key_p0, 2);
  assign w3  = key_word(key_p0, 3);
  assign w3n = w3 ^ w2;
  assign w2n = w2 ^ w1;
  assign w1n = w1 ^ w0;
  assign rot = {w3n[23:0], w3n[31:24]};

  for (genvar i = 0; i < 4; i++) begin : g_sbox
    aes_sbox u_sbox (.plain(rot[8*i +: 8]), .subst(sub[8*i +: 8]));
  end

  assign w0n      = w0 ^ sub ^ {rcon(rnd_p0), 24'h0};
  assign key_prev = words_to_key(w0n, w1n, w2n, w3n);

  // Accept a new round-10 key, step backwards on request, finish after key 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      key_p0    <= '0;
      addr_p0   <= '0;
      rnd_p0    <= '0;
      loaded_p0 <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (bus.key_in_valid) begin
            key_p0    <= bus.key_in;
            addr_p0   <= 4'(AES_NR + 1);
            rnd_p0    <= 4'(AES_NR);
            loaded_p0 <= 1'b0;
            state     <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (bus.key_next) begin
            if (addr_p0 > 4'd1) begin
              key_p0  <= key_prev;
              addr_p0 <= addr_p0 - 4'd1;
              rnd_p0  <= rnd_p0 - 4'd1;
            end else begin
              state     <= ST_DONE;
              addr_p0   <= '0;
              loaded_p0 <= 1'b1;
`ifdef AES_KEY_ZEROIZE_EN
              key_p0    <= '0;
`endif
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.key_in_ready = (state != ST_RUN);
  assign bus.key_out      = key_p0;
  assign bus.key_addr     = addr_p0;
  assign bus.key_loaded   = loaded_p0;

endmodule

// File: tb/tb_aes_key_reverse.sv
// Bench for aes_key_reverse: independent forward key expansion model
// (S-box derived from GF(2^8) inversion) feeding a scoreboard queue.
module tb_aes_key_reverse;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  aes_key_reverse_if bus ();
  aes_key_reverse dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct packed {
    logic [3:0]   addr;
    logic [127:0] key;
  } exp_t;

  exp_t         sb[$];
  int           n_cmp = 0;
  int           n_err = 0;
  logic [7:0]   sbox_m [256];
  logic [127:0] rk_m [11];

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, t;
    p = '0;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = xtime(t);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [15:0] t;
    t = {v, v} << n;
    return t[15:8];
  endfunction

  function automatic logic [31:0] bswap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  // Words listed w0..w3 in FIPS notation -> bus byte order.
  function automatic logic [127:0] pack4(input logic [31:0] a, input logic [31:0] b,
                                         input logic [31:0] c, input logic [31:0] d);
    return {bswap(d), bswap(c), bswap(b), bswap(a)};
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox_m[w[31:24]], sbox_m[w[23:16]], sbox_m[w[15:8]], sbox_m[w[7:0]]};
  endfunction

  // Forward expansion; rk_m[r] is round r, i.e. address r+1.
  task automatic expand(input logic [127:0] ck);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    for (int j = 0; j < 4; j++) w[j] = bswap(ck[32*j +: 32]);
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xtime(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++)
      rk_m[r] = pack4(w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]);
  endtask

  task automatic push_expected(input logic [127:0] ck);
    expand(ck);
    for (int a = 11; a >= 1; a--) sb.push_back({4'(a), rk_m[a-1]});
  endtask

  // Present a key for one cycle with key_next high; returns at the
  // falling edge where address 11 should be visible.
  task automatic load_key(input logic [127:0] k);
    @(negedge clk);
    bus.key_in       = k;
    bus.key_in_valid = 1'b1;
    bus.key_next     = 1'b1;
    @(negedge clk);
    bus.key_in_valid = 1'b0;
    bus.key_in       = {$urandom, $urandom, $urandom, $urandom};
  endtask

  function automatic logic [127:0] done_key(input logic [127:0] k1);
`ifdef AES_KEY_ZEROIZE_EN
    return (k1 & 128'h0);
`else
    return k1;
`endif
  endfunction

  function automatic logic [127:0] rand_key();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic test_reset();
    rst_n            = 1'b0;
    bus.key_in_valid = 1'b0;
    bus.key_in       = '0;
    bus.key_next     = 1'b0;
    #12;
    n_cmp++;
    if ({bus.key_in_ready, bus.key_loaded, bus.key_addr, bus.key_out} !== {1'b1, 1'b0, 4'd0, 128'h0}) begin
      n_err++;
      $display("FAIL reset_held: rdy=%b ld=%b addr=%0d key=%h, want rdy=1 ld=0 addr=0 key=0",
               bus.key_in_ready, bus.key_loaded, bus.key_addr, bus.key_out);
    end
    @(negedge clk);
    rst_n        = 1'b1;
    bus.key_next = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({bus.key_in_ready, bus.key_loaded, bus.key_addr, bus.key_out} !== {1'b1, 1'b0, 4'd0, 128'h0}) begin
      n_err++;
      $display("FAIL idle_next_ignored: rdy=%b ld=%b addr=%0d key=%h, want rdy=1 ld=0 addr=0 key=0",
               bus.key_in_ready, bus.key_loaded, bus.key_addr, bus.key_out);
    end
  endtask

  task automatic test_fips_walk();
    exp_t         e;
    logic [127:0] spec_k;
    logic         has_spec;
    push_expected(128'h3c4fcf09_8815f7ab_a6d2ae28_16157e2b);
    load_key(128'ha60c63b6_c80c3fe1_8925eec9_a8f914d0);
    for (int i = 0; i < 11; i++) begin
      if (i > 0) @(negedge clk);
      e = sb.pop_front();
      n_cmp++;
      if ({bus.key_in_ready, bus.key_addr, bus.key_out} !== {1'b0, e.addr, e.key}) begin
        n_err++;
        $display("FAIL fips_walk: rdy=%b addr=%0d key=%h, want rdy=0 addr=%0d key=%h",
                 bus.key_in_ready, bus.key_addr, bus.key_out, e.addr, e.key);
      end
      has_spec = 1'b1;
      case (e.addr)
        4'd11:   spec_k = pack4(32'hd014f9a8, 32'hc9ee2589, 32'he13f0cc8, 32'hb6630ca6);
        4'd10:   spec_k = pack4(32'hac7766f3, 32'h19fadc21, 32'h28d12941, 32'h575c006e);
        4'd2:    spec_k = pack4(32'ha0fafe17, 32'h88542cb1, 32'h23a33939, 32'h2a6c7605);
        4'd1:    spec_k = pack4(32'h2b7e1516, 32'h28aed2a6, 32'habf71588, 32'h09cf4f3c);
        default: begin spec_k = '0; has_spec = 1'b0; end
      endcase
      if (has_spec) begin
        n_cmp++;
        if (bus.key_out !== spec_k) begin
          n_err++;
          $display("FAIL fips_vector_addr%0d: got %h want %h", e.addr, bus.key_out, spec_k);
        end
      end
    end
    @(negedge clk);
    n_cmp++;
    if ({bus.key_in_ready, bus.key_loaded, bus.key_addr, bus.key_out} !==
        {1'b1, 1'b1, 4'd0, done_key(pack4(32'h2b7e1516, 32'h28aed2a6, 32'habf71588, 32'h09cf4f3c))}) begin
      n_err++;
      $display("FAIL fips_done: rdy=%b ld=%b addr=%0d key=%h", bus.key_in_ready, bus.key_loaded,
               bus.key_addr, bus.key_out);
    end
  endtask

  task automatic test_stall();
    exp_t e;
    push_expected(rand_key());
    load_key(rk_m[10]);
    for (int i = 0; i < 11; i++) begin
      if (i > 0) @(negedge clk);
      e = sb.pop_front();
      n_cmp++;
      if ({bus.key_addr, bus.key_out} !== {e.addr, e.key}) begin
        n_err++;
        $display("FAIL stall_walk: addr=%0d key=%h, want addr=%0d key=%h", bus.key_addr, bus.key_out, e.addr, e.key);
      end
      if (e.addr == 4'd6) begin
        bus.key_next = 1'b0;
        for (int s = 0; s < 5; s++) begin
          @(negedge clk);
          n_cmp++;
          if ({bus.key_addr, bus.key_out} !== {e.addr, e.key}) begin
            n_err++;
            $display("FAIL stall_hold: addr=%0d key=%h, want addr=%0d key=%h", bus.key_addr, bus.key_out, e.addr, e.key);
          end
        end
        bus.key_next = 1'b1;
      end
    end
    @(negedge clk);
    n_cmp++;
    if ({bus.key_loaded, bus.key_addr, bus.key_out} !== {1'b1, 4'd0, done_key(rk_m[0])}) begin
      n_err++;
      $display("FAIL stall_done: ld=%b addr=%0d key=%h", bus.key_loaded, bus.key_addr, bus.key_out);
    end
  endtask

  task automatic test_reset_mid_run();
    exp_t e;
    push_expected(rand_key());
    load_key(rk_m[10]);
    for (int i = 0; i < 11; i++) begin
      if (i > 0) @(negedge clk);
      e = sb.pop_front();
      if (e.addr == 4'd7) begin
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({bus.key_in_ready, bus.key_loaded, bus.key_addr, bus.key_out} !== {1'b1, 1'b0, 4'd0, 128'h0}) begin
          n_err++;
          $display("FAIL reset_mid_run: rdy=%b ld=%b addr=%0d key=%h, want rdy=1 ld=0 addr=0 key=0",
                   bus.key_in_ready, bus.key_loaded, bus.key_addr, bus.key_out);
        end
        break;
      end
    end
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    push_expected(rand_key());
    load_key(rk_m[10]);
    for (int i = 0; i < 11; i++) begin
      if (i > 0) @(negedge clk);
      e = sb.pop_front();
      n_cmp++;
      if ({bus.key_addr, bus.key_out} !== {e.addr, e.key}) begin
        n_err++;
        $display("FAIL reload_walk: addr=%0d key=%h, want addr=%0d key=%h", bus.key_addr, bus.key_out, e.addr, e.key);
      end
    end
    @(negedge clk);
    n_cmp++;
    if ({bus.key_loaded, bus.key_addr} !== {1'b1, 4'd0}) begin
      n_err++;
      $display("FAIL reload_done: ld=%b addr=%0d, want ld=1 addr=0", bus.key_loaded, bus.key_addr);
    end
  endtask

  // Entered in DONE: reload with key_next still high, then poke valid in RUN.
  task automatic test_back_to_back();
    exp_t e;
    push_expected(rand_key());
    load_key(rk_m[10]);
    for (int i = 0; i < 11; i++) begin
      if (i > 0) @(negedge clk);
      e = sb.pop_front();
      n_cmp++;
      if (i == 0 && bus.key_loaded !== 1'b0) begin
        n_err++;
        $display("FAIL b2b_loaded_clear: got %b want 0", bus.key_loaded);
      end else if ({bus.key_addr, bus.key_out} !== {e.addr, e.key}) begin
        n_err++;
        $display("FAIL b2b_walk: addr=%0d key=%h, want addr=%0d key=%h", bus.key_addr, bus.key_out, e.addr, e.key);
      end
      if (e.addr == 4'd9) begin
        n_cmp++;
        if (bus.key_in_ready !== 1'b0) begin
          n_err++;
          $display("FAIL b2b_ready_in_run: got %b want 0", bus.key_in_ready);
        end
        bus.key_in       = rand_key();
        bus.key_in_valid = 1'b1;
        @(negedge clk);
        bus.key_in_valid = 1'b0;
        e = sb.pop_front();
        n_cmp++;
        if ({bus.key_addr, bus.key_out} !== {e.addr, e.key}) begin
          n_err++;
          $display("FAIL b2b_valid_ignored: addr=%0d key=%h, want addr=%0d key=%h", bus.key_addr, bus.key_out, e.addr, e.key);
        end
        i++;
      end
    end
    @(negedge clk);
    n_cmp++;
    if ({bus.key_in_ready, bus.key_loaded, bus.key_addr} !== {1'b1, 1'b1, 4'd0}) begin
      n_err++;
      $display("FAIL b2b_done: rdy=%b ld=%b addr=%0d", bus.key_in_ready, bus.key_loaded, bus.key_addr);
    end
  endtask

  task automatic test_round_trip();
    exp_t e;
    for (int k = 0; k < 1000; k++) begin
      push_expected(rand_key());
      load_key(rk_m[10]);
      for (int i = 0; i < 11; i++) begin
        if (i > 0) @(negedge clk);
        e = sb.pop_front();
        n_cmp++;
        if ({bus.key_addr, bus.key_out} !== {e.addr, e.key}) begin
          n_err++;
          $display("FAIL round_trip key%0d: addr=%0d key=%h, want addr=%0d key=%h",
                   k, bus.key_addr, bus.key_out, e.addr, e.key);
        end
      end
      @(negedge clk);
      n_cmp++;
      if ({bus.key_loaded, bus.key_addr, bus.key_out} !== {1'b1, 4'd0, done_key(rk_m[0])}) begin
        n_err++;
        $display("FAIL round_trip_done key%0d: ld=%b addr=%0d key=%h, want ld=1 addr=0 key=%h",
                 k, bus.key_loaded, bus.key_addr, bus.key_out, done_key(rk_m[0]));
      end
    end
  endtask

  initial begin
    build_sbox();
    test_reset();
    test_fips_walk();
    test_stall();
    test_reset_mid_run();
    test_back_to_back();
    test_round_trip();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
